// File: rtl/fp_pipe_multiplier.sv
// Pipelined IEEE-754 multiplier: unpack -> mantissa multiply -> normalise/round -> pack/exceptions.
// Flush-to-zero on subnormal inputs, round-to-nearest-even, valid/ready with a global stall.
module fp_pipe_multiplier #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   inexact
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic sign_c, spec_c, spec_inv_c;
  logic [W-1:0] spec_res_c;
  logic signed [EW-1:0] esum_c;

  // Special cases are resolved up front and ride the pipe beside the arithmetic path.
  always_comb begin
    a_zero     = ~|ea;
    b_zero     = ~|eb;
    a_nan      = (&ea) && (|fa);
    b_nan      = (&eb) && (|fb);
    a_inf      = (&ea) && !(|fa);
    b_inf      = (&eb) && !(|fb);
    sign_c     = a[W-1] ^ b[W-1];
    esum_c     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    spec_c     = 1'b1;
    spec_inv_c = 1'b0;
    spec_res_c = QNAN;
    if (a_nan || b_nan)
      spec_inv_c = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
    else if ((a_inf && b_zero) || (a_zero && b_inf))
      spec_inv_c = 1'b1;
    else if (a_inf || b_inf)
      spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero || b_zero)
      spec_res_c = {sign_c, {(W-1){1'b0}}};
    else
      spec_c = 1'b0;
  end

  logic                 s1_valid, s1_sign, s1_spec, s1_spec_inv;
  logic [TAG_W-1:0]     s1_tag;
  logic signed [EW-1:0] s1_esum;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic [W-1:0]         s1_spec_res;

  logic                 s2_valid, s2_sign, s2_spec, s2_spec_inv;
  logic [TAG_W-1:0]     s2_tag;
  logic signed [EW-1:0] s2_esum;
  logic [PW-1:0]        s2_prod;
  logic [W-1:0]         s2_spec_res;

  logic                 s3_valid, s3_sign, s3_spec, s3_spec_inv, s3_inexact;
  logic [TAG_W-1:0]     s3_tag;
  logic signed [EW-1:0] s3_exp;
  logic [MAN_W-1:0]     s3_frac;
  logic [W-1:0]         s3_spec_res;

  logic [PW-1:0]        ext;
  logic [MAN_W:0]       mant, rsum;
  logic                 norm, guard, rnd, sticky, carry;
  logic signed [EW-1:0] exp_c;

  always_comb begin
    norm   = s2_prod[PW-1];
    ext    = norm ? s2_prod : (s2_prod << 1);
    mant   = ext[PW-1:MAN_W+1];
    guard  = ext[MAN_W];
    rnd    = ext[MAN_W-1];
    sticky = |ext[MAN_W-2:0];
    rsum   = mant + (MAN_W+1)'(guard && (rnd || sticky || mant[0]));
    // Hidden bit is always 1 before rounding, so it reads 0 only after a carry-out (fraction is then 0).
    carry  = ~rsum[MAN_W];
    exp_c  = s2_esum + EW'(norm) + EW'(carry);
  end

  logic [W-1:0] res_c;
  logic         ov_c, uf_c, inv_c, inx_c;

  always_comb begin
    res_c = {s3_sign, s3_exp[EXP_W-1:0], s3_frac};
    ov_c  = 1'b0;
    uf_c  = 1'b0;
    inv_c = 1'b0;
    inx_c = s3_inexact;
    if (s3_spec) begin
      res_c = s3_spec_res;
      inv_c = s3_spec_inv;
      inx_c = 1'b0;
    end else if (s3_exp >= EMAX) begin
      res_c = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ov_c  = 1'b1;
      inx_c = 1'b1;
    end else if (s3_exp[EW-1] || s3_exp == '0) begin
      res_c = {s3_sign, {(W-1){1'b0}}};
      uf_c  = 1'b1;
      inx_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_sign <= 1'b0; s1_spec <= 1'b0; s1_spec_inv <= 1'b0;
      s1_tag <= '0; s1_esum <= '0; s1_ma <= '0; s1_mb <= '0; s1_spec_res <= '0;
      s2_valid <= 1'b0; s2_sign <= 1'b0; s2_spec <= 1'b0; s2_spec_inv <= 1'b0;
      s2_tag <= '0; s2_esum <= '0; s2_prod <= '0; s2_spec_res <= '0;
      s3_valid <= 1'b0; s3_sign <= 1'b0; s3_spec <= 1'b0; s3_spec_inv <= 1'b0;
      s3_inexact <= 1'b0; s3_tag <= '0; s3_exp <= '0; s3_frac <= '0; s3_spec_res <= '0;
      out_valid <= 1'b0; result <= '0; out_tag <= '0;
      overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_tag      <= in_tag;
      s1_sign     <= sign_c;
      s1_esum     <= esum_c;
      s1_ma       <= {1'b1, fa};
      s1_mb       <= {1'b1, fb};
      s1_spec     <= spec_c;
      s1_spec_inv <= spec_inv_c;
      s1_spec_res <= spec_res_c;

      s2_valid    <= s1_valid;
      s2_tag      <= s1_tag;
      s2_sign     <= s1_sign;
      s2_esum     <= s1_esum;
      s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
      s2_spec     <= s1_spec;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_res <= s1_spec_res;

      s3_valid    <= s2_valid;
      s3_tag      <= s2_tag;
      s3_sign     <= s2_sign;
      s3_exp      <= exp_c;
      s3_frac     <= rsum[MAN_W-1:0];
      s3_inexact  <= guard || rnd || sticky;
      s3_spec     <= s2_spec;
      s3_spec_inv <= s2_spec_inv;
      s3_spec_res <= s2_spec_res;

      out_valid   <= s3_valid;
      out_tag     <= s3_tag;
      result      <= res_c;
      overflow    <= ov_c;
      underflow   <= uf_c;
      invalid     <= inv_c;
      inexact     <= inx_c;
    end
  end
endmodule

// File: tb/tb_fp_pipe_multiplier.sv
// Bench for fp_pipe_multiplier (FP32): directed special cases plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_fp_pipe_multiplier;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, overflow, underflow, invalid, inexact;
  logic [31:0] a = '0, b = '0, result;
  logic [TAG_W-1:0] in_tag = '0, out_tag;

  always #5 clk = ~clk;

  fp_pipe_multiplier #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .inexact(inexact)
  );

  typedef struct {
    logic [31:0]      res;
    logic [3:0]       fl;
    logic [TAG_W-1:0] tag;
    int unsigned      acc;
    bit               lat3;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int unsigned tests = 0, fails = 0, cyc = 0, delivered = 0;
  bit held_valid = 0, expect_stall = 0, last_in_fire = 0;
  logic [31:0] held_res;
  logic [TAG_W-1:0] held_tag;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Flags packed as {overflow, underflow, invalid, inexact}.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] fl);
    int ex, ey, e, k;
    longint unsigned fx, fy, p, q, rem, half;
    bit xn, yn, xi, yi, xz, yz, sg;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    xn = (ex == 255) && (fx != 0);
    yn = (ey == 255) && (fy != 0);
    xi = (ex == 255) && (fx == 0);
    yi = (ey == 255) && (fy == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    sg = x[31] ^ y[31];
    fl = 4'b0000;
    r  = 32'h7FC00000;
    if (xn || yn) begin
      fl[1] = (xn && !x[22]) || (yn && !y[22]);
    end else if ((xi && yz) || (xz && yi)) begin
      fl[1] = 1'b1;
    end else if (xi || yi) begin
      r = {sg, 8'hFF, 23'h0};
    end else if (xz || yz) begin
      r = {sg, 31'h0};
    end else begin
      p    = ((64'd1 << 23) + fx) * ((64'd1 << 23) + fy);
      k    = (p >= (64'd1 << 47)) ? 24 : 23;
      q    = p >> k;
      rem  = p & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        k = k + 1;
      end
      e = ex + ey - 127 + (k - 23);
      if (e >= 255) begin
        r = {sg, 8'hFF, 23'h0};
        fl = 4'b1001;
      end else if (e <= 0) begin
        r = {sg, 31'h0};
        fl = 4'b0101;
      end else begin
        r = {sg, 8'(e), 23'(q)};
        fl[0] = (rem != 0);
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [22:0] f;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    f = ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 3)) : 23'($urandom);
    case (sel)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = '0; end
      2:       e = 8'hFF;
      3:       e = 8'($urandom_range(1, 12));
      4:       e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(90, 164));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic step();
    bit in_fire, out_fire;
    exp_t e;
    #1;
    if (out_ready) check("in_ready_adv", in_ready, 1);
    if (expect_stall) check("stall_in_ready", in_ready, 0);
    if (held_valid) begin
      check("hold_valid", out_valid, 1);
      check("hold_result", result, held_res);
      check("hold_tag", out_tag, held_tag);
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        delivered++;
        check("result", result, e.res);
        check("flags", {overflow, underflow, invalid, inexact}, e.fl);
        check("tag", out_tag, e.tag);
        if (e.lat3) check("latency", cyc - e.acc, 3);
      end
    end
    held_valid = out_valid && !out_ready;
    held_res   = result;
    held_tag   = out_tag;
    @(posedge clk);
    cyc++;
    if (in_fire) begin
      cur.acc = cyc;
      cur.tag = in_tag;
      sb.push_back(cur);
    end
    last_in_fire = in_fire;
    @(negedge clk);
  endtask

  task automatic prep(input logic [31:0] x, input logic [31:0] y, input int unsigned tag, input bit lat3);
    a = x;
    b = y;
    in_tag = TAG_W'(tag);
    ref_mul(x, y, cur.res, cur.fl);
    cur.lat3 = lat3;
  endtask

  task automatic drain(input int unsigned budget);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int unsigned n = 0; n < budget && sb.size() != 0; n++) step();
    check("drain_empty", sb.size(), 0);
    repeat (4) step();
  endtask

  task automatic single(input logic [31:0] x, input logic [31:0] y, input int unsigned tag,
                        input logic [31:0] r, input logic [3:0] fl);
    a = x;
    b = y;
    in_tag = TAG_W'(tag);
    cur.res = r;
    cur.fl = fl;
    cur.lat3 = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    check("single_accept", last_in_fire, 1);
    drain(20);
  endtask

  initial begin
    int unsigned op, base, tagc;
    bit pending;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_tag", out_tag, 0);
    check("rst_flags", {overflow, underflow, invalid, inexact}, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    single(32'h41200000, 32'hC1A00000, 3,  32'hC3480000, 4'b0000);
    single(32'h7F7FFFFF, 32'h40000000, 1,  32'h7F800000, 4'b1001);
    single(32'h00800000, 32'h00800000, 2,  32'h00000000, 4'b0101);
    single(32'h7F800000, 32'h00000000, 4,  32'h7FC00000, 4'b0010);
    single(32'h7F800000, 32'h3F800000, 5,  32'h7F800000, 4'b0000);
    single(32'h7F800000, 32'h7FC00000, 6,  32'h7FC00000, 4'b0000);
    single(32'h3F800001, 32'h3F800001, 7,  32'h3F800002, 4'b0001);
    single(32'h00000000, 32'hBF800000, 8,  32'h80000000, 4'b0000);
    single(32'h7F800001, 32'h3F800000, 9,  32'h7FC00000, 4'b0010);
    single(32'h00000001, 32'h3F800000, 10, 32'h00000000, 4'b0000);
    single(32'h3FC00000, 32'h3F800001, 11, 32'h3FC00002, 4'b0001);
    single(32'h3FC00000, 32'h3F800003, 12, 32'h3FC00004, 4'b0001);

    // Backpressure: six back-to-back ops, consumer stalls for four cycles from cycle 4.
    base = delivered;
    op = 0;
    for (int i = 0; i < 40; i++) begin
      if (op < 6) begin
        if (!in_valid) begin
          prep({1'b0, 8'($urandom_range(100, 150)), 23'($urandom)},
               {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)}, op, 1'b0);
          in_valid = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(i >= 4 && i < 8);
      expect_stall = (i >= 4 && i < 8);
      step();
      expect_stall = 0;
      if (last_in_fire) begin
        op++;
        in_valid = 1'b0;
      end
      if (op == 6 && sb.size() == 0) break;
    end
    check("bp_delivered", delivered - base, 6);
    drain(20);

    // Randomized traffic with random gaps and random backpressure.
    pending = 0;
    tagc = 0;
    for (int i = 0; i < 300; i++) begin
      if (!pending) begin
        if ($urandom_range(0, 9) < 8) begin
          prep(rand_fp(), rand_fp(), tagc, 1'b0);
          tagc++;
          in_valid = 1'b1;
          pending = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_in_fire) pending = 0;
    end
    drain(60);

    // Reset with operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prep(32'h3F800000 + 32'(i), 32'h40400000, 13 + i, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    #1;
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_tag", out_tag, 0);
    check("midrst_flags", {overflow, underflow, invalid, inexact}, 0);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    held_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(32'h3F800000, 32'h40000000, 1, 32'h40000000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
